onewire_slave: RTL and testbench

ONEWIRE_SLAVE -- requirements
Module: onewire_slave

---
 rtl/onewire_pkg.sv | 28 ++
 rtl/onewire_sync.sv | 29 ++
 rtl/onewire_slave.sv | 131 +++++++++++++
 tb/tb_onewire_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-wire definitions: FSM state encoding, default bus timing
// constants and a saturating counter helper. The master uses these too.
package onewire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_LOW,
      ST_PRES_WAIT,
      ST_PRES_DRIVE,
      ST_SLOT_WAIT,
      ST_SLOT_LOW,
      ST_SLOT_HOLD
   } ow_state_t;

   localparam int unsigned RST_MIN_DEF   = 40;
   localparam int unsigned PRES_DLY_DEF  = 2;
   localparam int unsigned PRES_LEN_DEF  = 8;
   localparam int unsigned SLOT_HOLD_DEF = 6;
   localparam int unsigned NBITS_DEF     = 32;

   localparam int CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the 1-wire bus plus a falling-edge detector
// on the synchronised level. Flops reset to 1 (idle bus is pulled high).
module onewire_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic fall
);

   logic s1, s2, prev;

   // Synchroniser chain and one-cycle history of the synchronised level.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign level = s2;
   assign fall  = prev & ~s2;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire slave that answers a bus RESET with a presence pulse and then
// shifts out an NBITS package MSB first, one bit per master read slot.
// A zero bit is signalled by holding the bus low after the master lets go.
module onewire_slave
   import onewire_pkg::*;
#(
   parameter int unsigned RST_MIN   = RST_MIN_DEF,
   parameter int unsigned PRES_DLY  = PRES_DLY_DEF,
   parameter int unsigned PRES_LEN  = PRES_LEN_DEF,
   parameter int unsigned SLOT_HOLD = SLOT_HOLD_DEF,
   parameter int unsigned NBITS     = NBITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire              port,
   input  logic [NBITS-1:0] data,
   input  logic             load,
   output logic             en,
   output logic             busy,
   output logic             done,
   output logic [5:0]       bit_cnt
);

   ow_state_t        state, state_nxt;
   logic             level, fall;
   logic [CNT_W-1:0] lcnt;
   logic [CNT_W-1:0] tcnt;
   logic [NBITS-1:0] shreg;
   logic [31:0]      lcnt_x, tcnt_x, bcnt_x;

   // Open-drain: only ever pull low, the external pull-up supplies the high.
   assign port = en ? 1'b0 : 1'bz;

   onewire_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (port),
      .level (level),
      .fall  (fall)
   );

   assign lcnt_x = 32'(lcnt);
   assign tcnt_x = 32'(tcnt);
   assign bcnt_x = 32'(bit_cnt);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode plus the bus-drive and busy outputs.
   // The cycle in which the RESET release is first seen counts as the first
   // presence-delay cycle, so presence starts PRES_DLY cycles after the
   // synchronised release.
   always_comb begin
      state_nxt = state;
      en        = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!level) state_nxt = ST_RST_LOW;
         end
         ST_RST_LOW: begin
            if (level) state_nxt = (lcnt_x >= RST_MIN) ? ST_PRES_WAIT : ST_IDLE;
         end
         ST_PRES_WAIT: begin
            if (tcnt_x + 32'd2 >= PRES_DLY) state_nxt = ST_PRES_DRIVE;
         end
         ST_PRES_DRIVE: begin
            en   = 1'b1;
            busy = 1'b1;
            if (tcnt_x + 32'd1 >= PRES_LEN) state_nxt = ST_SLOT_WAIT;
         end
         ST_SLOT_WAIT: begin
            busy = 1'b1;
            if (fall) state_nxt = ST_SLOT_LOW;
         end
         ST_SLOT_LOW: begin
            busy = 1'b1;
            if (level)                  state_nxt = ST_SLOT_HOLD;
            else if (lcnt_x >= RST_MIN) state_nxt = ST_RST_LOW;
         end
         ST_SLOT_HOLD: begin
            busy = 1'b1;
            en   = ~shreg[NBITS-1];
            if (tcnt_x + 32'd1 >= SLOT_HOLD)
               state_nxt = (bcnt_x + 32'd1 >= NBITS) ? ST_IDLE : ST_SLOT_WAIT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Low-time and per-state timers; both saturate. The low counter is kept
   // across a slot abort so the long low already seen still qualifies as RESET.
   always_ff @(posedge clk) begin
      if (reset) begin
         lcnt <= '0;
         tcnt <= '0;
      end else begin
         if (state_nxt != state) tcnt <= '0;
         else                    tcnt <= sat_inc(tcnt);
         case (state)
            ST_IDLE, ST_SLOT_WAIT:   lcnt <= '0;
            ST_RST_LOW, ST_SLOT_LOW: if (!level) lcnt <= sat_inc(lcnt);
            default:                 lcnt <= lcnt;
         endcase
      end
   end

   // Package shift register, bit index and completion pulse. Vacated bits
   // fill with ones so an exhausted or unloaded register reads back as 1s.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '1;
         bit_cnt <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load && (state == ST_IDLE || state == ST_RST_LOW)) shreg <= data;
         if (state == ST_IDLE) bit_cnt <= '0;
         if (state == ST_PRES_DRIVE && state_nxt == ST_SLOT_WAIT) bit_cnt <= '0;
         if (state == ST_SLOT_HOLD && state_nxt != ST_SLOT_HOLD) begin
            shreg   <= {shreg[NBITS-2:0], 1'b1};
            bit_cnt <= bit_cnt + 6'd1;
            done    <= (state_nxt == ST_IDLE);
         end
      end
   end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: a behavioural bus master drives RESET
// pulses and read slots on a pulled-up open-drain wire.
`timescale 1ns/1ps
module tb_onewire_slave;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic [31:0] data  = 32'h0;
   logic        mlow  = 1'b0;
   logic        en, busy, done;
   logic [5:0]  bit_cnt;
   wire         bus;

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;

   pullup (bus);
   assign bus = mlow ? 1'b0 : 1'bz;

   onewire_slave dut (
      .clk     (clk),
      .reset   (reset),
      .port    (bus),
      .data    (data),
      .load    (load),
      .en      (en),
      .busy    (busy),
      .done    (done),
      .bit_cnt (bit_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      mlow = 1'b0; load = 1'b0; reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   // Pull the bus low for n cycles; returns 1ns after the release edge.
   task automatic master_low(input int n);
      @(posedge clk); #1 mlow = 1'b1;
      repeat (n) @(posedge clk);
      #1 mlow = 1'b0;
   endtask

   // Read slot: 3-cycle low, release, sample 4 cycles later, recover.
   task automatic read_slot(output logic b);
      master_low(3);
      tick(4);
      b = bus;
      tick(10);
   endtask

   task automatic do_load(input logic [31:0] d);
      data = d; load = 1'b1;
      tick(1);
      load = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; mlow = 1'b0;
      tick(3);
      checks++; if (en !== 1'b0)       begin errors++; $display("FAIL reset_en: got %b expected 0", en); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (bit_cnt !== 6'd0)  begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
      checks++; if (bus !== 1'b1)      begin errors++; $display("FAIL reset_bus: got %b expected 1", bus); end
      reset = 1'b0;
   endtask

   task automatic test_presence;
      logic exp_en, exp_busy, b;
      do_reset;
      master_low(50);
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         exp_en   = (i >= 4 && i <= 11);
         exp_busy = (i >= 4);
         checks++; if (en !== exp_en)     begin errors++; $display("FAIL pres_en[+%0d]: got %b expected %b", i, en, exp_en); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL pres_busy[+%0d]: got %b expected %b", i, busy, exp_busy); end
         checks++; if (bus !== ~exp_en)   begin errors++; $display("FAIL pres_bus[+%0d]: got %b expected %b", i, bus, ~exp_en); end
      end
      checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL pres_bit_cnt: got %0d expected 0", bit_cnt); end
      read_slot(b);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL unloaded_bit: got %b expected 1", b); end
   endtask

   task automatic test_short_pulse;
      logic seen;
      do_reset;
      master_low(20);
      seen = 1'b0;
      repeat (16) begin
         tick(1);
         if (en !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL short_no_presence: got %b expected 0", seen); end
      master_low(50);
      tick(3);
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL short_then_reset_en3: got %b expected 0", en); end
      tick(1);
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL short_then_reset_en4: got %b expected 1", en); end
   endtask

   task automatic test_package;
      logic [31:0] got;
      logic        b, cnt_bad;
      int          d0;
      do_reset;
      do_load(32'hA5A5_0F0F);
      master_low(50);
      tick(14);
      d0 = done_cnt;
      got = '0;
      cnt_bad = 1'b0;
      for (int i = 0; i < 31; i++) begin
         if (bit_cnt !== 6'(i)) cnt_bad = 1'b1;
         read_slot(b);
         got = {got[30:0], b};
      end
      checks++; if (cnt_bad !== 1'b0) begin errors++; $display("FAIL pkg_bit_cnt_seq: got %b expected 0", cnt_bad); end
      master_low(3);
      tick(4);
      got = {got[30:0], bus};
      tick(4);
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL pkg_done_early: got %b expected 0", done); end
      checks++; if (bit_cnt !== 6'd31) begin errors++; $display("FAIL pkg_bit_cnt31: got %0d expected 31", bit_cnt); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL pkg_busy_last: got %b expected 1", busy); end
      tick(1);
      checks++; if (done !== 1'b1)     begin errors++; $display("FAIL pkg_done: got %b expected 1", done); end
      checks++; if (bit_cnt !== 6'd32) begin errors++; $display("FAIL pkg_bit_cnt32: got %0d expected 32", bit_cnt); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL pkg_busy_end: got %b expected 0", busy); end
      tick(1);
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL pkg_done_pulse: got %b expected 0", done); end
      checks++; if (bit_cnt !== 6'd0)  begin errors++; $display("FAIL pkg_bit_cnt_idle: got %0d expected 0", bit_cnt); end
      checks++; if (got !== 32'hA5A5_0F0F) begin errors++; $display("FAIL pkg_data: got %h expected a5a50f0f", got); end
      tick(2);
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL pkg_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_bit_timing;
      logic exp;
      do_reset;
      do_load(32'h4000_0000);
      master_low(50);
      tick(14);
      for (int s = 0; s < 2; s++) begin
         master_low(3);
         for (int i = 1; i <= 12; i++) begin
            tick(1);
            exp = (s == 0) ? !(i >= 3 && i <= 8) : 1'b1;
            checks++; if (bus !== exp) begin errors++; $display("FAIL slot%0d_bus[+%0d]: got %b expected %b", s, i, bus, exp); end
         end
         tick(3);
      end
   endtask

   task automatic test_abort;
      logic [10:0] got11;
      logic [3:0]  got4;
      logic        b;
      do_reset;
      do_load(32'hA5A5_0F0F);
      master_low(50);
      tick(14);
      got11 = '0;
      for (int i = 0; i < 11; i++) begin
         read_slot(b);
         got11 = {got11[9:0], b};
      end
      checks++; if (got11 !== 11'h52D) begin errors++; $display("FAIL abort_first11: got %h expected 52d", got11); end
      master_low(45);
      tick(3);
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL abort_en3: got %b expected 0", en); end
      tick(1);
      checks++; if (en !== 1'b1)   begin errors++; $display("FAIL abort_pres_en: got %b expected 1", en); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pres_busy: got %b expected 1", busy); end
      tick(8);
      checks++; if (en !== 1'b0)      begin errors++; $display("FAIL abort_pres_end: got %b expected 0", en); end
      checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL abort_bit_cnt: got %0d expected 0", bit_cnt); end
      do_load(32'hFFFF_FFFF);
      got4 = '0;
      for (int i = 0; i < 4; i++) begin
         read_slot(b);
         got4 = {got4[2:0], b};
      end
      checks++; if (got4 !== 4'h2) begin errors++; $display("FAIL abort_resume_bits: got %h expected 2", got4); end
   endtask

   task automatic test_reset_mid;
      logic b;
      do_reset;
      do_load(32'h0000_0000);
      master_low(50);
      tick(6);
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL mid_pres_en: got %b expected 1", en); end
      reset = 1'b1;
      tick(1);
      checks++; if (en !== 1'b0)      begin errors++; $display("FAIL mid_en: got %b expected 0", en); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
      checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL mid_bit_cnt: got %0d expected 0", bit_cnt); end
      checks++; if (bus !== 1'b1)     begin errors++; $display("FAIL mid_bus: got %b expected 1", bus); end
      reset = 1'b0;
      tick(2);
      master_low(50);
      tick(14);
      read_slot(b);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL mid_shreg_ones: got %b expected 1", b); end
   endtask

   initial begin
      test_reset;
      test_presence;
      test_short_pulse;
      test_package;
      test_bit_timing;
      test_abort;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
